univ_shift_reg: RTL



---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 27 ++
 rtl/univ_shift_reg.sv | 76 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: mode/state encodings and the burst-mode predicate for univ_shift_reg.
package shift_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m >= MODE_SHR) && (m <= MODE_ASR);
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational next-value unit shared by single-cycle and burst paths.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic             shl_in,
  input  logic             shr_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nxt
);
  always_comb begin
    nxt = q;
    case (mode)
      MODE_LOAD: nxt = d;
      MODE_SHR:  nxt = {shr_in, q[WIDTH-1:1]};
      MODE_SHL:  nxt = {q[WIDTH-2:0], shl_in};
      MODE_ROR:  nxt = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR:  nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  nxt = '0;
      default:   nxt = q;
    endcase
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with a counted burst sequencer.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             shl_in,
  input  logic             shr_in,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             shr_out,
  output logic             shl_out,
  output logic             busy,
  output logic             done
);
  logic [1:0]       state, state_nx;
  logic [2:0]       bmode;
  logic [CW-1:0]    rem;
  logic [WIDTH-1:0] q_nx;
  logic             accept, load_q;

  assign accept = (state == ST_IDLE) && start && is_burst_mode(mode) && (cnt != '0);
  // q holds on the accepting edge and throughout DONE
  assign load_q = ((state == ST_IDLE) && !accept) || (state == ST_RUN);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode   (state == ST_RUN ? bmode : mode),
    .q      (q),
    .shl_in (shl_in),
    .shr_in (shr_in),
    .d      (d),
    .nxt    (q_nx)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = accept ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nx = (rem == CW'(1)) ? ST_DONE : ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q     <= '0;
      rem   <= '0;
      bmode <= MODE_HOLD;
    end else begin
      if (accept) begin
        bmode <= mode;
        rem   <= cnt;
      end else if (state == ST_RUN) begin
        rem <= rem - CW'(1);
      end
      if (load_q) q <= q_nx;
    end

  assign shr_out = q[0];
  assign shl_out = q[WIDTH-1];
endmodule
